// File: rtl/cp0_intctl.sv
// CP0 interrupt controller: edge-latched pending bits, mask, EPC and a two-level IE stack.
// Define CP0_RR_PRIO_EN for round-robin selection; otherwise the lowest eligible index wins.
module cp0_intctl #(
  parameter int          NUM_IRQ    = 4,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0040
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] hwint,
  output logic [NUM_IRQ-1:0] irq_ack,
  input  logic [31:0]        pc_plus4,
  input  logic               mtc0,
  input  logic               mfc0,
  input  logic               rfe,
  input  logic [4:0]         cp0_sel,
  input  logic [31:0]        cp0_wdata,
  output logic [31:0]        cp0_rdata,
  output logic               exc_redirect,
  output logic [31:0]        exc_pc
);

  localparam logic [4:0] SEL_SR    = 5'd12;
  localparam logic [4:0] SEL_CAUSE = 5'd13;
  localparam logic [4:0] SEL_EPC   = 5'd14;

  logic               ie;
  logic               iep;
  logic [NUM_IRQ-1:0] im;
  logic [NUM_IRQ-1:0] ip;
  logic [NUM_IRQ-1:0] ip_next;
  logic [NUM_IRQ-1:0] hwint_q;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] take_vec;
  logic [2:0]         id;
  logic [2:0]         sel_id;
  logic [31:0]        epc;
  logic               wr_sr;
  logic               wr_cause;
  logic               wr_epc;
  logic               unused_wdata;

  function automatic logic [2:0] lowest(input logic [NUM_IRQ-1:0] v);
    logic [2:0] r;
    r = '0;
    for (int n = NUM_IRQ - 1; n >= 0; n--) begin
      if (v[n]) r = 3'(n);
    end
    return r;
  endfunction

  assign wr_sr        = mtc0 && (cp0_sel == SEL_SR);
  assign wr_cause     = mtc0 && (cp0_sel == SEL_CAUSE);
  assign wr_epc       = mtc0 && (cp0_sel == SEL_EPC);
  assign unused_wdata = ^{cp0_wdata[31:8+NUM_IRQ], cp0_wdata[7:2]};

  assign eligible     = ip & im;
  assign exc_redirect = ie & (|eligible) & ~rfe;
  assign exc_pc       = exc_redirect ? EXC_VECTOR : epc;

`ifdef CP0_RR_PRIO_EN
  logic [2:0]         rr_ptr;
  logic [NUM_IRQ-1:0] rot;
  logic [3:0]         rr_sum;
  logic [3:0]         rr_next;

  // Rotate so the search starts at rr_ptr, then map the winner back to a real index.
  assign rot     = NUM_IRQ'({eligible, eligible} >> rr_ptr);
  assign rr_sum  = {1'b0, lowest(rot)} + {1'b0, rr_ptr};
  assign sel_id  = (rr_sum >= 4'(NUM_IRQ)) ? 3'(rr_sum - 4'(NUM_IRQ)) : rr_sum[2:0];
  assign rr_next = {1'b0, sel_id} + 4'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (exc_redirect) begin
      rr_ptr <= (rr_next >= 4'(NUM_IRQ)) ? 3'd0 : rr_next[2:0];
    end
  end
`else
  assign sel_id = lowest(eligible);
`endif

  always_comb begin
    take_vec = '0;
    for (int n = 0; n < NUM_IRQ; n++) begin
      take_vec[n] = exc_redirect && (sel_id == 3'(n));
    end
  end

  // A new edge on a line beats both the W1C clear and the take clear.
  always_comb begin
    ip_next = ip;
    if (wr_cause) ip_next = ip_next & ~cp0_wdata[8 +: NUM_IRQ];
    ip_next = (ip_next & ~take_vec) | (hwint & ~hwint_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ie      <= 1'b0;
      iep     <= 1'b0;
      im      <= '0;
      ip      <= '0;
      hwint_q <= '0;
      id      <= '0;
      epc     <= '0;
      irq_ack <= '0;
    end else begin
      hwint_q <= hwint;
      ip      <= ip_next;
      irq_ack <= take_vec;
      if (wr_sr) begin
        im  <= cp0_wdata[8 +: NUM_IRQ];
        ie  <= cp0_wdata[0];
        iep <= cp0_wdata[1];
      end
      if (wr_epc) epc <= cp0_wdata;
      if (rfe) ie <= iep;
      // Take overrides any same-edge MTC0 to IE/IEp/EPC; rfe and take never coincide.
      if (exc_redirect) begin
        iep <= ie;
        ie  <= 1'b0;
        id  <= sel_id;
        epc <= pc_plus4;
      end
    end
  end

  always_comb begin
    cp0_rdata = '0;
    if (mfc0) begin
      case (cp0_sel)
        SEL_SR: begin
          cp0_rdata[0]            = ie;
          cp0_rdata[1]            = iep;
          cp0_rdata[8 +: NUM_IRQ] = im;
        end
        SEL_CAUSE: begin
          cp0_rdata[8 +: NUM_IRQ] = ip;
          cp0_rdata[4:2]          = id;
        end
        SEL_EPC: cp0_rdata = epc;
        default: cp0_rdata = '0;
      endcase
    end
  end

endmodule
